// File: rtl/cluster_unpacker768.sv
// Rebuilds a per-frame pad hit map from (adr, cnt) cluster words and publishes it on frame_end.
// Optional build macro UNPACKER_LATCH_DELAY_EN adds latch_delay[3:0] to postpone the frame close.
module cluster_unpacker768 #(
  parameter int MXPADS    = 768,
  parameter int MXCNTBITS = 8
) (
  input  logic                 clock,
  input  logic                 global_reset,
  input  logic                 clst_valid,
  input  logic [10:0]          adr,
  input  logic [2:0]           cnt,
  input  logic                 frame_end,
`ifdef UNPACKER_LATCH_DELAY_EN
  input  logic [3:0]           latch_delay,
`endif
  output logic [MXPADS-1:0]    vpfs_out,
  output logic                 map_valid,
  output logic [9:0]           n_clusters,
  output logic                 clip_flag,
  output logic [MXCNTBITS-1:0] err_cnt
);

  localparam logic [10:0] NO_CLUSTER = 11'h7FE;

  logic [MXPADS-1:0] work_map;
  logic [MXPADS-1:0] mask;
  logic [9:0]        frm_cnt;
  logic [9:0]        frm_cnt_nxt;
  logic              clip_work;
  logic              accept;
  logic              bad_adr;
  logic              clip_now;
  logic              fe_eff;
  int                adr_i;
  int                end_i;

`ifdef UNPACKER_LATCH_DELAY_EN
  logic [14:0] dly;

  always_ff @(posedge clock) begin
    if (global_reset) dly <= '0;
    else              dly <= {dly[13:0], frame_end};
  end

  // dly[k] holds frame_end from k+1 cycles ago
  always_comb begin
    fe_eff = frame_end;
    if (latch_delay != 4'd0) fe_eff = dly[latch_delay - 4'd1];
  end
`else
  assign fe_eff = frame_end;
`endif

  always_comb begin
    adr_i    = {21'd0, adr};
    end_i    = adr_i + {29'd0, cnt};
    accept   = clst_valid && (adr_i < MXPADS);
    bad_adr  = clst_valid && (adr_i >= MXPADS) && (adr != NO_CLUSTER);
    clip_now = accept && (end_i > MXPADS - 1);
    mask     = '0;
    for (int i = 0; i < MXPADS; i++)
      mask[i] = accept && (i >= adr_i) && (i <= end_i);
    frm_cnt_nxt = frm_cnt;
    if (accept && frm_cnt != 10'h3FF) frm_cnt_nxt = frm_cnt + 10'd1;
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      work_map   <= '0;
      frm_cnt    <= '0;
      clip_work  <= 1'b0;
      vpfs_out   <= '0;
      n_clusters <= '0;
      clip_flag  <= 1'b0;
      map_valid  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      map_valid <= fe_eff;
      // a cluster coincident with the close belongs to the closing frame
      if (fe_eff) begin
        vpfs_out   <= work_map | mask;
        n_clusters <= frm_cnt_nxt;
        clip_flag  <= clip_work | clip_now;
        work_map   <= '0;
        frm_cnt    <= '0;
        clip_work  <= 1'b0;
      end else begin
        work_map  <= work_map | mask;
        frm_cnt   <= frm_cnt_nxt;
        clip_work <= clip_work | clip_now;
      end
      if (bad_adr && err_cnt != {MXCNTBITS{1'b1}}) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
